core_sequencer: RTL

Multi-cycle control FSM for the tinywhisper RV32I core. It fetches each instruction, drives the shared ALU's 17-bit control word and operand selects, and handshakes with data memory for loads and stores. It also updates the PC from the ALU jump code (result bits [24:23]), generates register-file write strobes, and vectors to a trap on an illegal instruction or a bus timeout. The block sits between the instruction/data bus adapters, the register file and the ALU.

---
 rtl/core_pkg.sv | 55 +++++
 rtl/core_sequencer_bus_timeout.sv | 38 +++
 rtl/core_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the tinywhisper core sequencer.
package core_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TMO_W = 8;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_TRAP  = 3'd4
    } state_e;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        WSEL_ALU  = 2'b00,
        WSEL_LOAD = 2'b01,
        WSEL_PC4  = 2'b10
    } wsel_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_IMEM    = 2'b10,
        CAUSE_DMEM    = 2'b11
    } cause_e;

    // Jump codes carried in alu_result[24:23]
    localparam logic [1:0] JC_BRANCH = 2'b00;
    localparam logic [1:0] JC_JALR   = 2'b01;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic uses_imm(input logic [6:0] op);
        return (op == OP_IMM) || (op == OP_LUI) || (op == OP_AUIPC) ||
               (op == OP_LW)  || (op == OP_SW)  || (op == OP_JALR);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
        return !((op == OP_SW) || (op == OP_BRANCH) || (rd == 5'd0));
    endfunction

endpackage

// File: rtl/core_sequencer_bus_timeout.sv
// Wait-cycle counter shared by the instruction and data bus handshakes.
module bus_timeout
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c_o
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High during the last permitted wait cycle of an active request
    assign expired_c_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/execute/memory/writeback sequencer with trap entry.
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    input  logic [31:0] imm,
    output logic [31:0] ir,
    output logic [16:0] alu_instruction,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    input  logic [31:0] alu_result,
    input  logic        alu_illegal,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] mepc,
    output logic        retired
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d, ir_q, ir_d, mepc_q, mepc_d;
    cause_e            cause_q, cause_d;
    wsel_e             wsel_q, wsel_d;
    logic              imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic              a_sel_q, a_sel_d, b_sel_q, b_sel_d;
    logic              rf_we_q, rf_we_d, trap_q, trap_d, retired_q, retired_d;

    logic              trap_entry;
    cause_e            trap_code;
    logic              tmo_en, tmo_clr, tmo_expired;
    logic [6:0]        opcode, in_op;
    logic [1:0]        jump_code;

    assign opcode    = ir_q[6:0];
    assign in_op     = imem_rdata[6:0];
    assign jump_code = alu_result[24:23];

    // One counter serves both buses; it restarts whenever a handshake ends
    assign tmo_en  = imem_req_q || dmem_req_q;
    assign tmo_clr = !tmo_en || (imem_req_q && imem_ready) || (dmem_req_q && dmem_ready) ||
                     tmo_expired;

    bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (tmo_clr),
        .en_i        (tmo_en),
        .expired_c_o (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        mepc_d     = mepc_q;
        cause_d    = cause_q;
        wsel_d     = wsel_q;
        a_sel_d    = a_sel_q;
        b_sel_d    = b_sel_q;
        trap_entry = 1'b0;
        trap_code  = CAUSE_NONE;

        case (state_q)
            ST_FETCH: begin
                if (imem_req_q) begin
                    if (imem_ready) begin
                        ir_d    = imem_rdata;
                        a_sel_d = (in_op == OP_AUIPC);
                        b_sel_d = uses_imm(in_op);
                        state_d = ST_EXEC;
                    end else if (tmo_expired) begin
                        trap_entry = 1'b1;
                        trap_code  = CAUSE_IMEM;
                    end
                end
            end
            ST_EXEC: begin
                if (alu_illegal) begin
                    trap_entry = 1'b1;
                    trap_code  = CAUSE_ILLEGAL;
                end else if (is_mem_op(opcode)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_d = ST_WB;
                end else if (tmo_expired) begin
                    trap_entry = 1'b1;
                    trap_code  = CAUSE_DMEM;
                end
            end
            ST_WB: begin
                if ((opcode == OP_JAL) || ((opcode == OP_BRANCH) && (jump_code == JC_BRANCH))) begin
                    pc_d = pc_q + imm;
                end else if ((opcode == OP_JALR) && (jump_code == JC_JALR)) begin
                    pc_d = alu_result & 32'hFFFF_FFFE;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Trap bookkeeping lands on entry so it is visible alongside the pulse
        if (trap_entry) begin
            state_d = ST_TRAP;
            mepc_d  = pc_q;
            pc_d    = TRAP_VEC;
            cause_d = trap_code;
        end

        if (state_d == ST_WB) begin
            if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
                wsel_d = WSEL_PC4;
            end else if (opcode == OP_LW) begin
                wsel_d = WSEL_LOAD;
            end else begin
                wsel_d = WSEL_ALU;
            end
        end

        imem_req_d = (state_d == ST_FETCH);
        dmem_req_d = (state_d == ST_MEM);
        dmem_we_d  = (state_d == ST_MEM) && (opcode == OP_SW);
        rf_we_d    = (state_d == ST_WB) && writes_rd(opcode, ir_q[11:7]);
        retired_d  = (state_d == ST_WB);
        trap_d     = (state_d == ST_TRAP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            mepc_q     <= '0;
            cause_q    <= CAUSE_NONE;
            wsel_q     <= WSEL_ALU;
            a_sel_q    <= 1'b0;
            b_sel_q    <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            retired_q  <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mepc_q     <= mepc_d;
            cause_q    <= cause_d;
            wsel_q     <= wsel_d;
            a_sel_q    <= a_sel_d;
            b_sel_q    <= b_sel_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            rf_we_q    <= rf_we_d;
            retired_q  <= retired_d;
            trap_q     <= trap_d;
        end
    end

    assign imem_req        = imem_req_q;
    assign pc              = pc_q;
    assign ir              = ir_q;
    assign alu_instruction = {ir_q[31:25], ir_q[14:12], ir_q[6:0]};
    assign alu_a_sel       = a_sel_q;
    assign alu_b_sel       = b_sel_q;
    assign dmem_req        = dmem_req_q;
    assign dmem_we         = dmem_we_q;
    assign rf_we           = rf_we_q;
    assign rf_wsel         = wsel_q;
    assign trap            = trap_q;
    assign trap_cause      = cause_q;
    assign mepc            = mepc_q;
    assign retired         = retired_q;

endmodule
